// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings,
// default operand width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_adder_gatelevel.sv
// Gate-level 1-bit full adder cell.
module full_adder_gatelevel (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic axb;

    assign axb = a ^ b;
    assign s   = axb ^ cin;
    assign co  = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell processes one bit per cycle,
// LSB first. Three-state FSM (IDLE/RUN/DONE), synchronous active-high reset.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q, cout_q;
    logic [WIDTH-1:0]  b_in;
    logic              cin_in;
    logic              fa_s, fa_co;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && start;

    // Operand conditioning at capture: subtraction is a + ~b + 1.
    always_comb begin
        b_in   = b;
        cin_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in   = ~b;
            cin_in = 1'b1;
        end
`endif
    end

    full_adder_gatelevel u_fa (
        .a   (a_q[cnt_q]),
        .b   (b_q[cnt_q]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so start is never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= cin_in;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            sum_q[cnt_q] <= fa_s;
            carry_q      <= fa_co;
            cnt_q        <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                cout_q <= fa_co;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b;
    logic [W-1:0] sum;
    logic         cout, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int start_cnt = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Independent count of completion pulses.
    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns number of busy cycles seen.
    task automatic wait_done(input string tag, output int nbusy);
        int cyc;
        cyc   = 0;
        nbusy = 0;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            step();
            cyc++;
        end
        chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    endtask

    // Single start pulse, then check latency, result and hold behaviour.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [W:0] exp);
        int nb;
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        step();
        start = 1'b0;
        start_cnt++;
        wait_done(tag, nb);
        chk({tag, "_busycyc"}, nb, W);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[W-1:0]});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[W]});
        step();
        chk({tag, "_donepulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, {23'd0, cout, sum}, {23'd0, exp});
    endtask

    initial begin
        int nb;
        logic [W-1:0] ra, rb;
        logic         rc;
        int ds0, ss0;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        chk("rst_sum",  {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        run_op("v5a33", 8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D);
        run_op("vff01", 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        run_op("vff00c", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100);
        run_op("v8080c", 8'h80, 8'h80, 1'b1, 1'b0, 9'h101);
        run_op("v0000", 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        run_op("v7f01", 8'h7F, 8'h01, 1'b0, 1'b0, 9'h080);

        // Start held high: operands change mid-run, back-to-back with one IDLE gap.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        start_cnt++;
        chk("b2b_busy0", {31'd0, busy}, 32'd1);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        wait_done("b2b_first", nb);
        chk("b2b_first_sum", {24'd0, sum}, 32'h46);
        chk("b2b_first_cout", {31'd0, cout}, 32'd0);
        step();
        chk("b2b_idle_gap", {30'd0, busy, done}, 32'd0);
        step();
        start_cnt++;
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("b2b_second", nb);
        chk("b2b_second_sum", {24'd0, sum}, 32'hFF);
        chk("b2b_second_cout", {31'd0, cout}, 32'd1);
        step();

        // Reset at the 4th RUN cycle aborts without a done pulse.
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_outs", {22'd0, busy, done, cout, sum}, 32'd0);
        ds0 = done_cnt;
        for (int i = 0; i < 12; i++) step();
        chk("abort_no_done", done_cnt - ds0, 0);
        run_op("after_abort", 8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 9'h10F);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF);
`endif

        // Randomized additions against a + b + cin.
        ds0 = done_cnt;
        ss0 = start_cnt;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op("rand", ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        end
        chk("rand_done_count", done_cnt - ds0, start_cnt - ss0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, 8, operand width in bits; the block SHALL support any value from 2 to 32.
REQ-002 Port clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst input 1: synchronous, active-high reset.
REQ-004 Port start input 1: request to begin an operation; SHALL be sampled on rising edges.
REQ-005 Port a input WIDTH: operand A; SHALL be captured when start is accepted.
REQ-006 Port b input WIDTH: operand B; SHALL be captured when start is accepted.
REQ-007 Port cin input 1: carry-in; SHALL be captured when start is accepted.
REQ-008 Port sum output WIDTH: result register.
REQ-009 Port cout output 1: final carry-out.
REQ-010 Port busy output 1: an operation is in progress.
REQ-011 Port done output 1: single-cycle completion pulse.

Function
REQ-012 The block SHALL use exactly one 1-bit full-adder cell, time-shared across WIDTH cycles, one bit per cycle, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on a rising edge with start=1, capturing a, b and cin, clearing sum and loading bit counter=0.
REQ-015 In RUN, each edge SHALL add operand bits [i], feed the carry flop into the cell, write the cell's sum into sum[i], update the carry flop from the cell's carry and increment i.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 busy SHALL be 1 exactly while in RUN.
REQ-019 done SHALL be 1 exactly while in DONE.
REQ-020 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-021 sum and cout SHALL be valid when done=1 and SHALL hold until the next accepted start or reset.
REQ-022 cout SHALL equal the carry out of bit WIDTH-1.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing, and the in-flight result SHALL be unaffected.
REQ-024 Changes on a, b or cin after acceptance SHALL NOT affect the running operation.
REQ-025 Arithmetic: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).

Reset
REQ-026 While rst=1 at an edge, the FSM SHALL enter IDLE; sum, cout, busy, done, the counter, the carry flop and the operand registers SHALL be 0.
REQ-027 rst SHALL take priority over start.
REQ-028 Reset during RUN SHALL abort the operation, and done SHALL NOT pulse for the aborted operation.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN: when defined, the block SHALL add input port sub (1 bit), captured with start.
REQ-030 With SERIAL_ADDER_SUB_EN defined and sub=1, the block SHALL compute a - b as a + ~b + 1 (cin ignored), with cout=1 meaning no borrow.
REQ-031 Without SERIAL_ADDER_SUB_EN, port sub SHALL be absent and the behaviour SHALL be addition only.

Structure
REQ-032 The shared package/header SHALL hold: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH; counter width derived as clog2(WIDTH).
REQ-033 The block SHALL instantiate the team's existing gate-level 1-bit full adder (full_adder_gatelevel) as its sole sub-module, and SHALL contain no other adder logic.

Verification (WIDTH=8)
REQ-034 Scenario: a=0x5A, b=0x33, cin=0, start pulse -> busy for 8 cycles, then done 1 cycle; sum=0x8D, cout=0.
REQ-035 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-036 Scenario: start held high throughout -> back-to-back operations with one IDLE cycle between done and the next busy; operands changed during RUN -> first result unaffected.
REQ-037 Scenario: rst asserted at the 4th RUN cycle -> next cycle all outputs 0 and state IDLE; no done pulse; a new start completes correctly.
REQ-038 Scenario (SERIAL_ADDER_SUB_EN): sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x01, b=0x02 -> sum=0xFF, cout=0.
REQ-039 Randomized check: 1000 operands compared against a + b + cin; done count SHALL equal accepted start count.
